// File: rtl/nn_pkg.sv
// Shared definitions for the neuron datapath: word width, sequencer state
// encoding and Q1.31 constants.
package nn_pkg;

  localparam int DATA_W = 32;

  localparam logic [DATA_W-1:0] Q_ZERO     = 32'h0000_0000;
  localparam logic [DATA_W-1:0] Q_HALF     = 32'h4000_0000;
  localparam logic [DATA_W-1:0] Q_MAX      = 32'h7FFF_FFFF;
  localparam logic [DATA_W-1:0] Q_MIN      = 32'h8000_0000;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_MAC   = 3'd2,
    S_BIAS  = 3'd3,
    S_OUT   = 3'd4
  } state_t;

endpackage

// File: rtl/neuron_sequencer.sv
// Sequences an external Q1.31 MAC through clear, N products, bias add and
// optional ReLU, fetching operands from two synchronous-read buffers.
module neuron_sequencer
  import nn_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int WADDR_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [ADDR_W-1:0]  num_inputs,
  input  logic [WADDR_W-1:0] w_base,
  input  logic               relu_en,
  output logic               busy,
  output logic               in_rd_en,
  output logic [ADDR_W-1:0]  in_addr,
  input  logic [DATA_W-1:0]  in_rdata,
  output logic               w_rd_en,
  output logic [WADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0]  w_rdata,
  output logic               mac_zero,
  output logic               mac_isbias,
  output logic [DATA_W-1:0]  mac_input,
  output logic [DATA_W-1:0]  mac_weight,
  output logic [DATA_W-1:0]  mac_last,
  input  logic [DATA_W-1:0]  mac_out,
  output logic               result_valid,
  output logic [DATA_W-1:0]  result_data
);

  state_t              r_state, w_next;
  // One bit wider than num_inputs so k+1 never overflows for N = 2^ADDR_W-1.
  logic [ADDR_W:0]     r_k;
  logic [ADDR_W-1:0]   r_num;
  logic [WADDR_W-1:0]  r_wbase;
  logic                r_relu;

  logic [ADDR_W:0]     w_k_nxt;
  logic                w_k_last;
  logic                w_k_more;

  assign w_k_nxt  = r_k + (ADDR_W+1)'(1);
  assign w_k_last = (w_k_nxt == {1'b0, r_num});
  assign w_k_more = (w_k_nxt <  {1'b0, r_num});
  assign busy     = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_k          <= '0;
      r_num        <= '0;
      r_wbase      <= '0;
      r_relu       <= 1'b0;
      result_valid <= 1'b0;
      result_data  <= '0;
    end else begin
      r_state      <= w_next;
      result_valid <= (r_state == S_OUT);
      if (r_state == S_IDLE && start) begin
        r_num   <= num_inputs;
        r_wbase <= w_base;
        r_relu  <= relu_en;
      end
      if (r_state == S_CLEAR) r_k <= '0;
      if (r_state == S_MAC)   r_k <= w_k_nxt;
      if (r_state == S_OUT)
        result_data <= (r_relu && mac_out[DATA_W-1]) ? Q_ZERO : mac_out;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_CLEAR;
      S_CLEAR: w_next = (r_num == '0) ? S_BIAS : S_MAC;
      S_MAC:   if (w_k_last) w_next = S_BIAS;
      S_BIAS:  w_next = S_OUT;
      S_OUT:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // The MAC updates every edge, so idle states feed it last=out, x*w=0.
  always_comb begin
    mac_zero   = 1'b0;
    mac_isbias = 1'b0;
    mac_input  = '0;
    mac_weight = '0;
    mac_last   = mac_out;
    in_rd_en   = 1'b0;
    in_addr    = '0;
    w_rd_en    = 1'b0;
    w_addr     = '0;
    case (r_state)
      S_CLEAR: begin
        mac_zero = 1'b1;
        w_rd_en  = 1'b1;
        w_addr   = r_wbase;
        if (r_num != '0) in_rd_en = 1'b1;
      end
      S_MAC: begin
        mac_input  = in_rdata;
        mac_weight = w_rdata;
        w_rd_en    = 1'b1;
        w_addr     = r_wbase + WADDR_W'(r_k) + WADDR_W'(1);
        if (w_k_more) begin
          in_rd_en = 1'b1;
          in_addr  = ADDR_W'(w_k_nxt);
        end
      end
      S_BIAS: begin
        mac_isbias = 1'b1;
        mac_weight = w_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_neuron_sequencer.sv
// Bench for neuron_sequencer: behavioural MAC and buffers, vector table plus
// scoreboard checking result value and cycle of arrival.
module tb_neuron_sequencer;
  import nn_pkg::*;

  localparam int ADDR_W  = 8;
  localparam int WADDR_W = 16;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic [ADDR_W-1:0]  num_inputs = '0;
  logic [WADDR_W-1:0] w_base = '0;
  logic               relu_en = 1'b0;
  logic               busy, in_rd_en, w_rd_en;
  logic [ADDR_W-1:0]  in_addr;
  logic [WADDR_W-1:0] w_addr;
  logic [31:0]        in_rdata, w_rdata;
  logic               mac_zero, mac_isbias;
  logic [31:0]        mac_input, mac_weight, mac_last, mac_out;
  logic               result_valid;
  logic [31:0]        result_data;

  always #5 clk = ~clk;

  neuron_sequencer #(.ADDR_W(ADDR_W), .WADDR_W(WADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_inputs(num_inputs),
    .w_base(w_base), .relu_en(relu_en), .busy(busy),
    .in_rd_en(in_rd_en), .in_addr(in_addr), .in_rdata(in_rdata),
    .w_rd_en(w_rd_en), .w_addr(w_addr), .w_rdata(w_rdata),
    .mac_zero(mac_zero), .mac_isbias(mac_isbias), .mac_input(mac_input),
    .mac_weight(mac_weight), .mac_last(mac_last), .mac_out(mac_out),
    .result_valid(result_valid), .result_data(result_data)
  );

  logic [31:0] in_mem [0:255];
  logic [31:0] w_mem  [0:65535];

  always @(posedge clk) begin
    if (in_rd_en) in_rdata <= in_mem[in_addr];
    if (w_rd_en)  w_rdata  <= w_mem[w_addr];
  end

  function automatic logic [31:0] mac_step(logic [31:0] a, logic [31:0] b, logic [31:0] last);
    logic signed [63:0] s;
    s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b})
      + ($signed({{32{last[31]}}, last}) <<< 31);
    return s[62:31];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)          mac_out <= 32'h0;
    else if (mac_zero)   mac_out <= 32'h0;
    else if (mac_isbias) mac_out <= mac_last + mac_weight;
    else                 mac_out <= mac_step(mac_input, mac_weight, mac_last);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] data; int due; } exp_t;
  exp_t sb[$];
  exp_t e;
  int   n_vec = 0;
  int   n_err = 0;
  logic cap = 1'b0;
  logic [31:0] wq[$];
  logic [31:0] iq[$];

  always @(negedge clk) begin
    if (result_valid) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_result cyc=%0d data=%h", cyc, result_data);
      end else begin
        e = sb.pop_front();
        if (result_data !== e.data || cyc != e.due) begin
          n_err++;
          $display("FAIL result got data=%h cyc=%0d want data=%h cyc=%0d",
                   result_data, cyc, e.data, e.due);
        end
      end
    end
    if (cap) begin
      if (w_rd_en)  wq.push_back(32'(w_addr));
      if (in_rd_en) iq.push_back(32'(in_addr));
    end
  end

  typedef struct {
    int               n;
    logic [15:0]      wb;
    logic             relu;
    logic [3:0][31:0] x;
    logic [3:0][31:0] w;
    logic [31:0]      bias;
    logic [31:0]      expv;
  } vec_t;

  vec_t vecs[8];

  function automatic vec_t mk(int n, logic [15:0] wb, logic relu,
                              logic [31:0] x0, logic [31:0] x1, logic [31:0] x2, logic [31:0] x3,
                              logic [31:0] w0, logic [31:0] w1, logic [31:0] w2, logic [31:0] w3,
                              logic [31:0] bias, logic [31:0] expv);
    vec_t v;
    v.n = n; v.wb = wb; v.relu = relu; v.bias = bias; v.expv = expv;
    v.x[0] = x0; v.x[1] = x1; v.x[2] = x2; v.x[3] = x3;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s got=%h want=%h", name, act, req);
    end
  endtask

  task automatic load(vec_t v);
    logic [15:0] a;
    for (int i = 0; i < v.n; i++) begin
      in_mem[i] = v.x[i];
      a = v.wb + 16'(i);
      w_mem[a] = v.w[i];
    end
    a = v.wb + 16'(v.n);
    w_mem[a] = v.bias;
  endtask

  task automatic drive(vec_t v, bit push);
    start      = 1'b1;
    num_inputs = ADDR_W'(v.n);
    w_base     = v.wb;
    relu_en    = v.relu;
    if (push) sb.push_back('{v.expv, cyc + v.n + 4});
  endtask

  // Leaves the bench one cycle after the accepting edge, with fields scrambled.
  task automatic kick(vec_t v, bit push);
    @(posedge clk); #1;
    drive(v, push);
    @(posedge clk); #1;
    start      = 1'b0;
    num_inputs = ADDR_W'($urandom);
    w_base     = WADDR_W'($urandom);
    relu_en    = 1'($urandom);
  endtask

  task automatic drain(string name);
    int b = 0;
    while (sb.size() != 0 && b < 300) begin
      @(posedge clk);
      b++;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s timeout pending=%0d", name, sb.size());
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_quiet(string tag);
    chk({tag, "_busy"},     32'(busy),         32'h0);
    chk({tag, "_in_rd"},    32'(in_rd_en),     32'h0);
    chk({tag, "_w_rd"},     32'(w_rd_en),      32'h0);
    chk({tag, "_in_addr"},  32'(in_addr),      32'h0);
    chk({tag, "_w_addr"},   32'(w_addr),       32'h0);
    chk({tag, "_rvalid"},   32'(result_valid), 32'h0);
    chk({tag, "_rdata"},    result_data,       32'h0);
    chk({tag, "_zero"},     32'(mac_zero),     32'h0);
    chk({tag, "_isbias"},   32'(mac_isbias),   32'h0);
    chk({tag, "_input"},    mac_input,         32'h0);
    chk({tag, "_weight"},   mac_weight,        32'h0);
  endtask

  logic [31:0] w_exp_seq[3];
  logic [31:0] i_exp_seq[2];
  vec_t vr, va;
  int   c0;

  initial begin
    vecs[0] = mk(2, 16'h0010, 1'b0, 32'h40000000, 32'h40000000, 0, 0,
                 32'h40000000, 32'h20000000, 0, 0, 32'h08000000, 32'h38000000);
    vecs[1] = mk(0, 16'h0020, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hF0000000, 32'hF0000000);
    vecs[2] = mk(0, 16'h0020, 1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 32'hF0000000, 32'h00000000);
    vecs[3] = mk(1, 16'h0030, 1'b1, 32'h40000000, 0, 0, 0,
                 32'hC0000000, 0, 0, 0, 32'h0, 32'h00000000);
    vecs[4] = mk(1, 16'h0030, 1'b0, 32'h40000000, 0, 0, 0,
                 32'hC0000000, 0, 0, 0, 32'h0, 32'hE0000000);
    vecs[5] = mk(3, 16'h0100, 1'b0, 32'h20000000, 32'hE0000000, 32'h10000000, 0,
                 32'h40000000, 32'h40000000, 32'h80000000, 0, 32'h01000000, 32'hF1000000);
    vecs[6] = mk(1, 16'h0200, 1'b1, 32'h40000000, 0, 0, 0,
                 32'h40000000, 0, 0, 0, 32'h10000000, 32'h30000000);
    vecs[7] = mk(4, 16'h0400, 1'b1, 32'h40000000, 32'hC0000000, 32'h40000000, 32'h40000000,
                 32'h10000000, 32'h20000000, 32'h08000000, 32'h08000000, 32'h00000000, 32'h00000000);
    // 7: 0.0625 - 0.125 + 0.03125 + 0.03125 = 0, relu leaves 0

    repeat (3) @(posedge clk);
    #1;
    chk_quiet("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      load(vecs[i]);
      kick(vecs[i], 1'b1);
      drain($sformatf("vec%0d", i));
    end

    // start during t2..t(N+3) is ignored; start in the result cycle is taken
    load(vecs[5]);
    kick(vecs[5], 1'b1);
    c0 = cyc - 1;
    for (int t = 1; t <= 6; t++) begin
      chk($sformatf("busy_t%0d", t), 32'(busy), 32'h1);
      if (t == 2 || t == 6) drive(vecs[6], 1'b0);
      else start = 1'b0;
      @(posedge clk); #1;
    end
    chk("b2b_cycle", 32'(cyc - c0), 32'd7);
    chk("b2b_idle", 32'(busy), 32'h0);
    drive(vecs[5], 1'b1);
    @(posedge clk); #1;
    start = 1'b0;
    drain("b2b");

    // reset during MAC k=1 of N=4
    vr = mk(4, 16'h0300, 1'b0, 32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000,
            32'h10000000, 32'h10000000, 32'h10000000, 32'h10000000, 32'h0, 32'h20000000);
    load(vr);
    kick(vr, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("k1_in_addr", 32'(in_addr), 32'h2);
    chk("k1_w_addr",  32'(w_addr),  32'h0302);
    #1 rst_n = 1'b0;
    #1;
    chk_quiet("midrst");
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    kick(vr, 1'b1);
    drain("after_reset");

    // address wrap at the top of the weight space
    va = vecs[0];
    va.wb = 16'hFFFE;
    load(va);
    wq.delete();
    iq.delete();
    cap = 1'b1;
    kick(va, 1'b1);
    drain("wrap");
    cap = 1'b0;
    w_exp_seq[0] = 32'hFFFE; w_exp_seq[1] = 32'hFFFF; w_exp_seq[2] = 32'h0000;
    i_exp_seq[0] = 32'h0;    i_exp_seq[1] = 32'h1;
    chk("wrap_w_count",  32'(wq.size()), 32'd3);
    chk("wrap_in_count", 32'(iq.size()), 32'd2);
    for (int i = 0; i < 3; i++)
      chk($sformatf("wrap_w_addr%0d", i), (wq.size() > i) ? wq[i] : 32'hDEADBEEF, w_exp_seq[i]);
    for (int i = 0; i < 2; i++)
      chk($sformatf("wrap_in_addr%0d", i), (iq.size() > i) ? iq[i] : 32'hDEADBEEF, i_exp_seq[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
